// File: rtl/kbd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : kbd_pkg
// Brief    : Shared constants, FSM state and event type for the button matrix.
// Revision : 1.0 - initial release
// ============================================================================
package kbd_pkg;
    localparam int NUM_COL = 5;
    localparam int NUM_ROW = 5;
    localparam int NUM_KEY = 25;
    localparam int CODE_W  = 5;
    localparam int EVT_W   = 6;

    typedef enum logic [1:0] {
        DRIVE  = 2'd0,
        SETTLE = 2'd1,
        PROC   = 2'd2
    } state_t;

    typedef struct packed {
        logic              press;
        logic [CODE_W-1:0] code;
    } evt_t;
endpackage
`default_nettype wire

// File: rtl/evt_fifo.sv
`default_nettype none
// ============================================================================
// Module   : evt_fifo
// Brief    : Synchronous FIFO with registered storage and combinational head.
// Revision : 1.0 - initial release
// ============================================================================
module evt_fifo #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_pop;
    logic             w_wr;

    // A pop frees a slot in the same cycle, so a push into a full FIFO still lands.
    assign w_pop   = i_pop && !o_empty;
    assign w_wr    = i_push && (!o_full || w_pop);
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_head  = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end
endmodule
`default_nettype wire

// File: rtl/btn_matrix_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : btn_matrix_ctrl
// Brief    : 5x5 button matrix scanner with debounce and press/release events.
// Revision : 1.0 - initial release
// ============================================================================
module btn_matrix_ctrl
    import kbd_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 256,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic               clk,
    input  logic               rst,
    output logic [NUM_COL-1:0] btn_x,
    input  logic [NUM_ROW-1:0] btn_y,
    output logic [NUM_KEY-1:0] key_state,
    output logic               evt_valid,
    output logic [EVT_W-1:0]   evt_data,
    input  logic               evt_ready,
    output logic               overflow,
    input  logic               clr_overflow
);
    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam int SET_W = $clog2(SETTLE_CYCLES);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [2:0]         r_col;
    logic [2:0]         r_row;
    logic [CODE_W-1:0]  r_key;
    logic [SET_W-1:0]   r_settle;
    logic [NUM_ROW-1:0] r_sync1;
    logic [NUM_ROW-1:0] r_sync2;
    logic [NUM_ROW-1:0] r_row_snap;
    logic [NUM_COL-1:0] r_btn_x;
    logic [NUM_KEY-1:0] r_key_state;
    logic [CNT_W-1:0]   r_cnt [NUM_KEY];
    logic               r_overflow;

    logic               w_sample;
    logic               w_level;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic               w_flip;
    evt_t               w_evt;
    logic               w_full;
    logic               w_empty;
    logic               w_drop;

    assign btn_x     = r_btn_x;
    assign key_state = r_key_state;
    assign overflow  = r_overflow;
    assign evt_valid = !w_empty;

    // Rows are inverted ahead of the flops so a reset value of 0 reads as "released".
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= ~btn_y;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= DRIVE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sample    = 1'b0;
        w_level     = 1'b0;
        w_cnt_inc   = '0;
        w_flip      = 1'b0;
        w_evt       = '0;
        case (r_state)
            DRIVE:  w_state_nxt = SETTLE;
            SETTLE: if (r_settle == '0) w_state_nxt = PROC;
            PROC: begin
                if (r_row == 3'(NUM_ROW - 1)) w_state_nxt = DRIVE;
                w_sample  = r_row_snap[r_row];
                w_level   = r_key_state[r_key];
                w_cnt_inc = r_cnt[r_key] + 1'b1;
                w_flip    = (w_sample != w_level) && (w_cnt_inc == CNT_W'(DEBOUNCE_SCANS));
                w_evt     = '{press: ~w_level, code: r_key};
            end
            default: w_state_nxt = DRIVE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col       <= '0;
            r_row       <= '0;
            r_key       <= '0;
            r_settle    <= '0;
            r_row_snap  <= '0;
            r_btn_x     <= '1;
            r_key_state <= '0;
            for (int i = 0; i < NUM_KEY; i++) r_cnt[i] <= '0;
        end else begin
            case (r_state)
                DRIVE: begin
                    r_btn_x  <= ~(5'b00001 << r_col);
                    r_settle <= SET_W'(SETTLE_CYCLES - 1);
                end
                SETTLE: begin
                    if (r_settle == '0) r_row_snap <= r_sync2;
                    else                r_settle   <= r_settle - 1'b1;
                end
                PROC: begin
                    if (w_sample == w_level) r_cnt[r_key] <= '0;
                    else                     r_cnt[r_key] <= w_flip ? '0 : w_cnt_inc;
                    if (w_flip) r_key_state[r_key] <= ~w_level;
                    r_key <= (r_key == CODE_W'(NUM_KEY - 1)) ? '0 : r_key + 1'b1;
                    if (r_row == 3'(NUM_ROW - 1)) begin
                        r_row <= '0;
                        r_col <= (r_col == 3'(NUM_COL - 1)) ? '0 : r_col + 1'b1;
                    end else begin
                        r_row <= r_row + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Full FIFO only accepts when its head leaves in the same cycle.
    assign w_drop = w_flip && w_full && !(evt_valid && evt_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)               r_overflow <= 1'b0;
        else if (w_drop)       r_overflow <= 1'b1;
        else if (clr_overflow) r_overflow <= 1'b0;
    end

    evt_fifo #(
        .WIDTH (EVT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_evt_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_flip),
        .i_data  (w_evt),
        .i_pop   (evt_ready),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (evt_data)
    );
endmodule
`default_nettype wire

// File: tb/tb_btn_matrix_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_btn_matrix_ctrl
// Brief    : Self-checking bench for btn_matrix_ctrl with a frame-level key model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_btn_matrix_ctrl;
    localparam int SETTLE = 4;
    localparam int DEB    = 2;
    localparam int DEPTH  = 4;
    localparam int FRAME  = (1 + SETTLE + 5) * 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  btn_x;
    logic [4:0]  btn_y;
    logic [24:0] key_state;
    logic        evt_valid;
    logic [5:0]  evt_data;
    logic        evt_ready = 1'b0;
    logic        overflow;
    logic        clr_overflow = 1'b0;

    int          checks = 0;
    int          errors = 0;
    int          evt_seen = 0;
    logic        mon_en = 1'b0;
    logic [24:0] keys = '0;
    logic [24:0] lvl = '0;
    int          run [25];
    logic [5:0]  exp_q [$];

    always #5 clk = ~clk;

    btn_matrix_ctrl #(
        .SETTLE_CYCLES  (SETTLE),
        .DEBOUNCE_SCANS (DEB),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_x        (btn_x),
        .btn_y        (btn_y),
        .key_state    (key_state),
        .evt_valid    (evt_valid),
        .evt_data     (evt_data),
        .evt_ready    (evt_ready),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    // Physical matrix: a held key pulls its row low while its column is driven.
    always_comb begin
        btn_y = '1;
        for (int c = 0; c < 5; c++)
            if (!btn_x[c])
                for (int r = 0; r < 5; r++)
                    if (keys[c*5+r]) btn_y[r] = 1'b0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One frame samples every key once; a key flips after DEB consecutive disagreeing frames.
    task automatic model_frame(input logic [24:0] k);
        for (int i = 0; i < 25; i++) begin
            if (k[i] == lvl[i]) begin
                run[i] = 0;
            end else begin
                run[i] = run[i] + 1;
                if (run[i] == DEB) begin
                    lvl[i] = k[i];
                    run[i] = 0;
                    exp_q.push_back({k[i], 5'(i)});
                end
            end
        end
    endtask

    task automatic model_reset();
        lvl = '0;
        for (int i = 0; i < 25; i++) run[i] = 0;
        exp_q.delete();
    endtask

    task automatic run_frame(input logic [24:0] k);
        keys = k;
        model_frame(k);
        repeat (FRAME) @(negedge clk);
        chk("key_state", {7'b0, key_state}, {7'b0, lvl});
        if (mon_en) chk("evt_drained", exp_q.size(), 0);
    endtask

    task automatic wait_frame_start();
        logic [4:0] prev;
        logic       found;
        prev  = btn_x;
        found = 1'b0;
        for (int i = 0; i < 4 * FRAME && !found; i++) begin
            @(negedge clk);
            if (btn_x == 5'b11110 && prev != 5'b11110) found = 1'b1;
            prev = btn_x;
        end
        chk("frame_sync", {31'b0, found}, 32'd1);
    endtask

    task automatic pulse_ready();
        evt_ready = 1'b1;
        @(negedge clk);
        evt_ready = 1'b0;
    endtask

    always @(negedge clk) begin
        logic [31:0] e;
        if (mon_en && evt_valid && evt_ready) begin
            evt_seen++;
            e = (exp_q.size() != 0) ? {26'b0, exp_q.pop_front()} : 32'hFFFF;
            chk("evt_stream", {26'b0, evt_data}, e);
        end
    end

    initial begin
        int base;
        logic [4:0]  exp_x;
        logic [24:0] t;
        model_reset();

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_btn_x", {27'b0, btn_x}, 32'h1F);
        chk("rst_valid", {31'b0, evt_valid}, 0);
        chk("rst_data", {26'b0, evt_data}, 0);
        chk("rst_keys", {7'b0, key_state}, 0);
        chk("rst_ovf", {31'b0, overflow}, 0);

        // Scan walk: each column held one column period, wrapping back to col 0
        rst = 1'b0;
        for (int k = 0; k <= FRAME; k++) begin
            @(negedge clk);
            exp_x = ~(5'b00001 << ((k / 10) % 5));
            chk("scan_walk", {27'b0, btn_x}, {27'b0, exp_x});
        end
        chk("walk_valid", {31'b0, evt_valid}, 0);

        // Single press / release of key 13
        mon_en = 1'b1;
        evt_ready = 1'b1;
        base = evt_seen;
        repeat (3) run_frame(25'(1) << 13);
        chk("press_key13", {31'b0, key_state[13]}, 1);
        chk("press_evt_count", evt_seen - base, 1);
        repeat (3) run_frame('0);
        chk("release_key13", {31'b0, key_state[13]}, 0);
        chk("release_evt_count", evt_seen - base, 2);

        // Bounce rejection on key 7
        base = evt_seen;
        for (int f = 0; f < 6; f++) run_frame((f % 2 == 0) ? (25'(1) << 7) : '0);
        chk("bounce_key7", {31'b0, key_state[7]}, 0);
        chk("bounce_no_evt", evt_seen - base, 0);

        // Handshake hold with two queued events
        mon_en = 1'b0;
        evt_ready = 1'b0;
        repeat (2) run_frame(25'b11);
        chk("hs_valid", {31'b0, evt_valid}, 1);
        chk("hs_first", {26'b0, evt_data}, 32'h20);
        repeat (4) @(negedge clk);
        chk("hs_hold", {26'b0, evt_data}, {26'b0, exp_q.pop_front()});
        pulse_ready();
        chk("hs_second", {26'b0, evt_data}, {26'b0, exp_q.pop_front()});
        chk("hs_valid2", {31'b0, evt_valid}, 1);
        pulse_ready();
        chk("hs_empty", {31'b0, evt_valid}, 0);
        chk("hs_empty_data", {26'b0, evt_data}, 0);

        // Overflow: five events into a four-deep FIFO
        wait_frame_start();
        repeat (2) run_frame(25'b11100);
        chk("ovf_set", {31'b0, overflow}, 1);
        for (int i = 0; i < DEPTH; i++) begin
            chk("ovf_valid", {31'b0, evt_valid}, 1);
            chk("ovf_order", {26'b0, evt_data}, {26'b0, exp_q.pop_front()});
            pulse_ready();
        end
        exp_q.delete();
        chk("ovf_drained", {31'b0, evt_valid}, 0);
        chk("ovf_sticky", {31'b0, overflow}, 1);
        clr_overflow = 1'b1;
        @(negedge clk);
        clr_overflow = 1'b0;
        chk("ovf_clear", {31'b0, overflow}, 0);

        // Reset during PROC with three events queued
        wait_frame_start();
        repeat (2) run_frame('0);
        repeat (6) @(negedge clk);
        chk("pre_rst_valid", {31'b0, evt_valid}, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", {31'b0, evt_valid}, 0);
        chk("mid_rst_keys", {7'b0, key_state}, 0);
        chk("mid_rst_btn_x", {27'b0, btn_x}, 32'h1F);
        chk("mid_rst_data", {26'b0, evt_data}, 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        chk("restart_col0", {27'b0, btn_x}, 32'h1E);

        // Randomized key activity against the frame model
        mon_en = 1'b1;
        evt_ready = 1'b1;
        for (int f = 0; f < 20; f++) begin
            t = 25'($urandom & $urandom);
            run_frame(keys ^ t);
        end
        repeat (3) run_frame(keys);
        chk("rand_no_ovf", {31'b0, overflow}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
